// File: rtl/vend_pkg.sv
// Shared types and constants for the vending credit controller.
// Holds the controller state encoding, the coin width and the change denominations.
package vend_pkg;

    localparam int COIN_W = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } state_t;

    localparam logic [COIN_W-1:0] DENOM_20 = 5'd20;
    localparam logic [COIN_W-1:0] DENOM_10 = 5'd10;
    localparam logic [COIN_W-1:0] DENOM_5  = 5'd5;
    localparam logic [COIN_W-1:0] DENOM_1  = 5'd1;

endpackage

// File: rtl/vend_change_pick.sv
// Change denomination picker: returns the largest coin of {20, 10, 5, 1}
// that does not exceed the credit still owed, or 0 when nothing is owed.
module vend_change_pick
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 6
) (
    input  logic [CREDIT_W-1:0] credit,
    output logic [COIN_W-1:0]   coin
);

    localparam logic [CREDIT_W-1:0] D20 = CREDIT_W'(DENOM_20);
    localparam logic [CREDIT_W-1:0] D10 = CREDIT_W'(DENOM_10);
    localparam logic [CREDIT_W-1:0] D5  = CREDIT_W'(DENOM_5);
    localparam logic [CREDIT_W-1:0] D1  = CREDIT_W'(DENOM_1);

    // Greedy pick, largest denomination first.
    always_comb begin
        // NOTE: default assignment first so every path drives coin and no latch is inferred.
        coin = '0;
        if (credit >= D20) begin
            coin = DENOM_20;
        end else if (credit >= D10) begin
            coin = DENOM_10;
        end else if (credit >= D5) begin
            coin = DENOM_5;
        end else if (credit >= D1) begin
            coin = DENOM_1;
        end
    end

endmodule

// File: rtl/vend_credit_ctrl.sv
// Vending machine credit controller: accumulates deposits, arbitrates
// cancel / select / deposit, pulses a vend and pays change coin by coin.
// Optional build macro VEND_TIMEOUT_EN adds an auto-refund after
// TIMEOUT_CYC idle cycles in CREDIT; without it timeout_o is tied 0.
module vend_credit_ctrl
    import vend_pkg::*;
#(
    parameter int CREDIT_W    = 6,
    parameter int CREDIT_MAX  = 50,
    parameter int PRICE0      = 15,
    parameter int PRICE1      = 25,
    parameter int PRICE2      = 30,
    parameter int PRICE3      = 45,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                deposit_valid_i,
    input  logic [COIN_W-1:0]   deposit_i,
    input  logic                sel_valid_i,
    input  logic [1:0]          sel_i,
    input  logic                cancel_i,
    input  logic                change_ready_i,
    output logic [CREDIT_W-1:0] credit_o,
    output logic                vend_o,
    output logic [1:0]          vend_item_o,
    output logic                change_valid_o,
    output logic [COIN_W-1:0]   change_coin_o,
    output logic                reject_o,
    output logic                insufficient_o,
    output logic                busy_o,
    output logic                timeout_o
);

    function automatic logic [CREDIT_W-1:0] price_of(input logic [1:0] idx);
        case (idx)
            2'd0:    price_of = CREDIT_W'(PRICE0);
            2'd1:    price_of = CREDIT_W'(PRICE1);
            2'd2:    price_of = CREDIT_W'(PRICE2);
            default: price_of = CREDIT_W'(PRICE3);
        endcase
    endfunction

    state_t              state;
    logic [CREDIT_W-1:0] credit;
    logic [1:0]          sel_q;
    logic [COIN_W-1:0]   coin;
    logic [CREDIT_W:0]   dep_sum;
    logic                dep_event;
    logic                dep_fits;
    logic                sel_served;
    logic                timer_hit;
    logic [CREDIT_W-1:0] vend_price;

    // Sum is one bit wider than credit so an overflowing deposit is visible.
    assign dep_sum    = {1'b0, credit} + (CREDIT_W+1)'(deposit_i);
    assign dep_fits   = dep_sum <= (CREDIT_W+1)'(CREDIT_MAX);
    assign dep_event  = deposit_valid_i && (deposit_i != '0);
    assign sel_served = sel_valid_i && (state == CREDIT) && (credit >= price_of(sel_i));
    assign vend_price = price_of(sel_q);

    vend_change_pick #(
        .CREDIT_W (CREDIT_W)
    ) u_pick (
        .credit (credit),
        .coin   (coin)
    );

    // Moore-decoded outputs; no input reaches an output without a register.
    assign credit_o       = credit;
    assign vend_o         = (state == VEND);
    assign vend_item_o    = sel_q;
    assign change_valid_o = (state == CHANGE);
    assign change_coin_o  = coin;
    assign busy_o         = (state == VEND) || (state == CHANGE);

`ifdef VEND_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TMR_W-1:0] timer;
    logic             dep_accept;

    assign dep_accept = dep_event && dep_fits && !sel_served;
    assign timer_hit  = (state == CREDIT) && (timer == TMR_W'(TIMEOUT_CYC - 1));

    // Idle counter in CREDIT; any user activity or leaving CREDIT restarts it.
    always_ff @(posedge clk_i) begin
        if (rst_i || state != CREDIT || cancel_i || timer_hit || sel_valid_i || dep_accept) begin
            timer <= '0;
        end else begin
            timer <= timer + TMR_W'(1);
        end
    end

    // Timeout pulse; a simultaneous cancel claims the refund instead.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= timer_hit && !cancel_i;
        end
    end
`else
    assign timer_hit = 1'b0;
    assign timeout_o = 1'b0;
`endif

    // Controller FSM with the credit register and the refusal pulses.
    always_ff @(posedge clk_i) begin
        // NOTE: reset is sampled on the clock edge, so it sits inside the clocked block.
        if (rst_i) begin
            state          <= IDLE;
            credit         <= '0;
            sel_q          <= '0;
            reject_o       <= 1'b0;
            insufficient_o <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            reject_o       <= 1'b0;
            insufficient_o <= 1'b0;
            unique case (state)
                IDLE, CREDIT: begin
                    if (cancel_i && state == CREDIT) begin
                        state <= CHANGE;
                    end else if (timer_hit) begin
                        state <= CHANGE;
                    end else if (sel_served) begin
                        state    <= VEND;
                        sel_q    <= sel_i;
                        reject_o <= dep_event;
                    end else begin
                        insufficient_o <= sel_valid_i;
                        if (dep_event) begin
                            if (dep_fits) begin
                                credit <= dep_sum[CREDIT_W-1:0];
                                state  <= CREDIT;
                            end else begin
                                reject_o <= 1'b1;
                            end
                        end
                    end
                end
                VEND: begin
                    reject_o <= dep_event;
                    credit   <= credit - vend_price;
                    state    <= (credit == vend_price) ? IDLE : CHANGE;
                end
                CHANGE: begin
                    reject_o <= dep_event;
                    if (change_ready_i) begin
                        credit <= credit - CREDIT_W'(coin);
                        if (credit == CREDIT_W'(coin)) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Self-checking bench for vend_credit_ctrl: directed scenarios plus a
// randomized run against a behavioural credit/payout model.
module tb_vend_credit_ctrl;

    localparam int TO_CYC = 8;
`ifdef VEND_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       deposit_valid_i = 1'b0;
    logic [4:0] deposit_i = '0;
    logic       sel_valid_i = 1'b0;
    logic [1:0] sel_i = '0;
    logic       cancel_i = 1'b0;
    logic       change_ready_i = 1'b0;
    logic [5:0] credit_o;
    logic       vend_o;
    logic [1:0] vend_item_o;
    logic       change_valid_o;
    logic [4:0] change_coin_o;
    logic       reject_o;
    logic       insufficient_o;
    logic       busy_o;
    logic       timeout_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int price[4] = '{15, 25, 30, 45};
    int m_credit, m_item, m_cnt;
    bit m_vend, m_pay, m_rej, m_ins, m_to;

    vend_credit_ctrl #(
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .deposit_valid_i (deposit_valid_i),
        .deposit_i       (deposit_i),
        .sel_valid_i     (sel_valid_i),
        .sel_i           (sel_i),
        .cancel_i        (cancel_i),
        .change_ready_i  (change_ready_i),
        .credit_o        (credit_o),
        .vend_o          (vend_o),
        .vend_item_o     (vend_item_o),
        .change_valid_o  (change_valid_o),
        .change_coin_o   (change_coin_o),
        .reject_o        (reject_o),
        .insufficient_o  (insufficient_o),
        .busy_o          (busy_o),
        .timeout_o       (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Apply inputs for one cycle; outputs are stable 1 time unit after the edge.
    task automatic drive(input bit dv, input int d, input bit sv, input int s,
                         input bit c, input bit r);
        deposit_valid_i = dv;
        deposit_i       = 5'(d);
        sel_valid_i     = sv;
        sel_i           = 2'(s);
        cancel_i        = c;
        change_ready_i  = r;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        rst_i = 1'b0;
    endtask

    function automatic int coin_of(input int c);
        int denoms[4] = '{20, 10, 5, 1};
        foreach (denoms[i]) if (c >= denoms[i]) return denoms[i];
        return 0;
    endfunction

    // Advance the model by one clock given the inputs applied in that cycle.
    task automatic model_step(input bit dv, input int d, input bit sv, input int s,
                              input bit c, input bit r);
        bit dep, acc, held;
        dep = dv && (d != 0);
        acc = 1'b0;
        m_rej = 0; m_ins = 0; m_to = 0;
        if (m_vend) begin
            m_credit = m_credit - price[m_item];
            m_vend = 0;
            m_pay = (m_credit > 0);
            m_rej = dep;
            m_cnt = 0;
        end else if (m_pay) begin
            if (r) m_credit = m_credit - coin_of(m_credit);
            m_pay = (m_credit > 0);
            m_rej = dep;
            m_cnt = 0;
        end else begin
            held = (m_credit > 0);
            if (c && held) begin
                m_pay = 1;
            end else if (TO_EN && held && m_cnt == TO_CYC - 1) begin
                m_pay = 1;
                m_to = 1;
            end else if (sv && held && m_credit >= price[s]) begin
                m_vend = 1;
                m_item = s;
                m_rej = dep;
            end else begin
                m_ins = sv;
                if (dep) begin
                    if (m_credit + d <= 50) begin
                        m_credit = m_credit + d;
                        acc = 1;
                    end else begin
                        m_rej = 1;
                    end
                end
            end
            if (held && !m_pay && !m_vend && !sv && !acc) m_cnt++;
            else m_cnt = 0;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        drive(1, 20, 1, 1, 1, 1);
        rst_i = 1'b0;
        n_checks++;
        if ({credit_o, vend_o, change_valid_o, reject_o, insufficient_o, busy_o, timeout_o} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got credit=%0d vend=%b cv=%b rej=%b ins=%b busy=%b to=%b, want all 0",
                     credit_o, vend_o, change_valid_o, reject_o, insufficient_o, busy_o, timeout_o);
        end
    endtask

    task automatic test_vend_with_change();
        do_reset();
        drive(1, 0, 0, 0, 0, 0);
        n_checks++;
        if (credit_o !== 6'd0 || reject_o !== 1'b0) begin
            n_errors++; $display("FAIL zero_deposit: got credit=%0d rej=%b, want 0 0", credit_o, reject_o);
        end
        drive(0, 0, 1, 0, 0, 0);
        n_checks++;
        if (insufficient_o !== 1'b1 || vend_o !== 1'b0) begin
            n_errors++; $display("FAIL idle_select: got ins=%b vend=%b, want 1 0", insufficient_o, vend_o);
        end
        drive(1, 20, 0, 0, 0, 0);
        n_checks++;
        if (credit_o !== 6'd20) begin n_errors++; $display("FAIL dep20: got %0d want 20", credit_o); end
        drive(1, 10, 0, 0, 0, 0);
        n_checks++;
        if (credit_o !== 6'd30) begin n_errors++; $display("FAIL dep30: got %0d want 30", credit_o); end
        drive(0, 0, 1, 1, 0, 1);
        n_checks++;
        if (vend_o !== 1'b1 || vend_item_o !== 2'd1 || busy_o !== 1'b1) begin
            n_errors++; $display("FAIL vend_pulse: got vend=%b item=%0d busy=%b, want 1 1 1", vend_o, vend_item_o, busy_o);
        end
        drive(0, 0, 0, 0, 0, 1);
        n_checks++;
        if (vend_o !== 1'b0 || credit_o !== 6'd5 || change_valid_o !== 1'b1 || change_coin_o !== 5'd5) begin
            n_errors++; $display("FAIL change5: got vend=%b credit=%0d cv=%b coin=%0d, want 0 5 1 5",
                                 vend_o, credit_o, change_valid_o, change_coin_o);
        end
        drive(0, 0, 0, 0, 0, 1);
        n_checks++;
        if (credit_o !== 6'd0 || change_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            n_errors++; $display("FAIL back_to_idle: got credit=%0d cv=%b busy=%b, want 0 0 0", credit_o, change_valid_o, busy_o);
        end
    endtask

    task automatic test_overflow_insufficient();
        do_reset();
        drive(1, 20, 0, 0, 0, 0);
        drive(1, 20, 0, 0, 0, 0);
        drive(1, 20, 0, 0, 0, 0);
        n_checks++;
        if (reject_o !== 1'b1 || credit_o !== 6'd40) begin
            n_errors++; $display("FAIL overflow_reject: got rej=%b credit=%0d, want 1 40", reject_o, credit_o);
        end
        drive(0, 0, 1, 3, 0, 0);
        n_checks++;
        if (insufficient_o !== 1'b1 || credit_o !== 6'd40 || vend_o !== 1'b0 || reject_o !== 1'b0) begin
            n_errors++; $display("FAIL insufficient: got ins=%b credit=%0d vend=%b rej=%b, want 1 40 0 0",
                                 insufficient_o, credit_o, vend_o, reject_o);
        end
        drive(0, 0, 0, 0, 0, 0);
        n_checks++;
        if (insufficient_o !== 1'b0) begin n_errors++; $display("FAIL ins_one_cycle: got %b want 0", insufficient_o); end
    endtask

    task automatic test_change_handshake();
        int coins[$];
        int exp_c[5] = '{20, 10, 5, 1, 1};
        do_reset();
        drive(1, 20, 0, 0, 0, 0);
        drive(1, 10, 0, 0, 0, 0);
        drive(1, 5, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0);
        n_checks++;
        if (credit_o !== 6'd37) begin n_errors++; $display("FAIL credit37: got %0d want 37", credit_o); end
        drive(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (change_valid_o !== 1'b1 || change_coin_o !== 5'd20 || credit_o !== 6'd37) begin
                n_errors++; $display("FAIL hold_coin%0d: got cv=%b coin=%0d credit=%0d, want 1 20 37",
                                     i, change_valid_o, change_coin_o, credit_o);
            end
            drive(0, 0, 0, 0, 0, 0);
        end
        for (int i = 0; i < 20 && change_valid_o === 1'b1; i++) begin
            coins.push_back(int'(change_coin_o));
            drive(0, 0, 0, 0, 0, 1);
        end
        n_checks++;
        if (coins.size() != 5 || change_valid_o !== 1'b0) begin
            n_errors++; $display("FAIL payout_len: got %0d coins cv=%b, want 5 coins cv=0", coins.size(), change_valid_o);
        end else begin
            foreach (exp_c[i]) begin
                n_checks++;
                if (coins[i] != exp_c[i]) begin
                    n_errors++; $display("FAIL payout_coin%0d: got %0d want %0d", i, coins[i], exp_c[i]);
                end
            end
        end
    endtask

    task automatic test_priority();
        int coins[$];
        bit saw_vend;
        do_reset();
        drive(1, 20, 0, 0, 0, 0);
        drive(1, 10, 0, 0, 0, 0);
        drive(1, 5, 1, 2, 1, 0);
        n_checks++;
        if (credit_o !== 6'd30 || vend_o !== 1'b0 || reject_o !== 1'b0 || change_valid_o !== 1'b1) begin
            n_errors++; $display("FAIL cancel_wins: got credit=%0d vend=%b rej=%b cv=%b, want 30 0 0 1",
                                 credit_o, vend_o, reject_o, change_valid_o);
        end
        saw_vend = 1'b0;
        for (int i = 0; i < 20 && change_valid_o === 1'b1; i++) begin
            coins.push_back(int'(change_coin_o));
            drive(0, 0, 0, 0, 0, 1);
            saw_vend |= vend_o;
        end
        n_checks++;
        if (coins.size() != 2 || saw_vend) begin
            n_errors++; $display("FAIL refund30_len: got %0d coins vend_seen=%b, want 2 coins 0", coins.size(), saw_vend);
        end else begin
            n_checks++;
            if (coins[0] != 20 || coins[1] != 10) begin
                n_errors++; $display("FAIL refund30_coins: got %0d,%0d want 20,10", coins[0], coins[1]);
            end
        end
    endtask

    task automatic test_reset_mid_change();
        do_reset();
        drive(1, 15, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0);
        drive(1, 5, 0, 0, 0, 0);
        n_checks++;
        if (reject_o !== 1'b1 || credit_o !== 6'd15 || change_coin_o !== 5'd10) begin
            n_errors++; $display("FAIL change_deposit: got rej=%b credit=%0d coin=%0d, want 1 15 10",
                                 reject_o, credit_o, change_coin_o);
        end
        do_reset();
        n_checks++;
        if (credit_o !== 6'd0 || change_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            n_errors++; $display("FAIL reset_in_change: got credit=%0d cv=%b busy=%b, want 0 0 0",
                                 credit_o, change_valid_o, busy_o);
        end
    endtask

`ifdef VEND_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        drive(1, 10, 0, 0, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            n_checks++;
            if (timeout_o !== (i == 8)) begin
                n_errors++; $display("FAIL timeout_idle%0d: got %b want %b", i, timeout_o, (i == 8));
            end
        end
        n_checks++;
        if (change_valid_o !== 1'b1 || change_coin_o !== 5'd10 || credit_o !== 6'd10) begin
            n_errors++; $display("FAIL timeout_refund: got cv=%b coin=%0d credit=%0d, want 1 10 10",
                                 change_valid_o, change_coin_o, credit_o);
        end
        drive(0, 0, 0, 0, 0, 1);
        n_checks++;
        if (credit_o !== 6'd0 || busy_o !== 1'b0 || timeout_o !== 1'b0) begin
            n_errors++; $display("FAIL timeout_idle: got credit=%0d busy=%b to=%b, want 0 0 0", credit_o, busy_o, timeout_o);
        end
    endtask
`else
    task automatic test_timeout();
        do_reset();
        drive(1, 10, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            n_checks++;
            if (timeout_o !== 1'b0 || change_valid_o !== 1'b0 || credit_o !== 6'd10) begin
                n_errors++; $display("FAIL no_timeout%0d: got to=%b cv=%b credit=%0d, want 0 0 10",
                                     i, timeout_o, change_valid_o, credit_o);
            end
        end
    endtask
`endif

    task automatic test_random();
        bit dv, sv, c, r;
        int d, s;
        do_reset();
        m_credit = 0; m_item = 0; m_cnt = 0;
        m_vend = 0; m_pay = 0; m_rej = 0; m_ins = 0; m_to = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            dv = ($urandom_range(0, 2) == 0);
            d  = $urandom_range(1, 20);
            sv = ($urandom_range(0, 5) == 0);
            s  = $urandom_range(0, 3);
            r  = ($urandom_range(0, 1) == 1);
            // Cancel with no credit is left out of the random mix.
            c  = ($urandom_range(0, 11) == 0) && (m_credit > 0 || m_vend || m_pay);
            model_step(dv, d, sv, s, c, r);
            drive(dv, d, sv, s, c, r);
            n_checks++;
            if (credit_o !== 6'(m_credit) || vend_o !== m_vend || change_valid_o !== m_pay ||
                busy_o !== (m_vend || m_pay) || reject_o !== m_rej || insufficient_o !== m_ins ||
                timeout_o !== m_to) begin
                n_errors++;
                $display("FAIL rand_c%0d: got credit=%0d vend=%b cv=%b busy=%b rej=%b ins=%b to=%b, want %0d %b %b %b %b %b %b",
                         cyc, credit_o, vend_o, change_valid_o, busy_o, reject_o, insufficient_o, timeout_o,
                         m_credit, m_vend, m_pay, m_vend || m_pay, m_rej, m_ins, m_to);
            end
            if (m_vend) begin
                n_checks++;
                if (vend_item_o !== 2'(m_item)) begin
                    n_errors++; $display("FAIL rand_item_c%0d: got %0d want %0d", cyc, vend_item_o, m_item);
                end
            end
            if (m_pay) begin
                n_checks++;
                if (change_coin_o !== 5'(coin_of(m_credit))) begin
                    n_errors++; $display("FAIL rand_coin_c%0d: got %0d want %0d", cyc, change_coin_o, coin_of(m_credit));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_vend_with_change();
        test_overflow_insufficient();
        test_change_handshake();
        test_priority();
        test_reset_mid_change();
        test_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vend_credit_ctrl.md
Name: vend_credit_ctrl

Overview:
Sequencing controller for the vending machine's coin-summing datapath.
- Takes each 5-bit deposit sum from the coin adder and accumulates it into a registered credit.
- Arbitrates the user's cancel, product select and deposit events.
- Issues a single-cycle vend pulse, then pays out change one coin per handshake, largest denomination first.

Parameters:
CREDIT_W, 6, width of credit register and credit_o
CREDIT_MAX, 50, highest credit that may be held; deposits that would exceed it are rejected
PRICE0, 15, price of item 0
PRICE1, 25, price of item 1
PRICE2, 30, price of item 2
PRICE3, 45, price of item 3
TIMEOUT_CYC, 1000, idle cycles before auto-refund (used only with the optional feature)

Ports:
clk_i  in  1  single clock, rising edge
rst_i  in  1  synchronous, active-high reset
deposit_valid_i  in  1  deposit_i carries a new coin batch this cycle
deposit_i  in  5  batch value from the coin adder (0..31)
sel_valid_i  in  1  product select strobe
sel_i  in  2  product index 0..3
cancel_i  in  1  refund request
change_ready_i  in  1  coin hopper accepts change_coin_o this cycle
credit_o  out  CREDIT_W  current credit
vend_o  out  1  one-cycle vend pulse
vend_item_o  out  2  item being vended, valid while vend_o=1
change_valid_o  out  1  change_coin_o valid
change_coin_o  out  5  denomination to pay: 20, 10, 5 or 1
reject_o  out  1  one-cycle pulse; deposit refused, coins returned by mechanism
insufficient_o  out  1  one-cycle pulse; select refused, credit below price
busy_o  out  1  high in VEND and CHANGE
timeout_o  out  1  one-cycle pulse on auto-refund (tied 0 without feature)

Behaviour:
- Reset: state IDLE, credit 0, all outputs 0. Reset in any state, including mid-CHANGE, discards remaining credit with no payout.
- States:
  - IDLE: credit = 0.
  - CREDIT: credit > 0.
  - VEND: one cycle.
  - CHANGE: paying out.
- Per-cycle event priority in IDLE/CREDIT: cancel_i, then sel_valid_i, then deposit_valid_i. Only the highest-priority event is acted on.
  - A deposit that loses arbitration to a select that is actually served (that cycle goes to VEND) pulses reject_o.
  - A deposit that loses to an insufficient select is still accepted.
- Deposit accept:
  - Only when credit + deposit_i <= CREDIT_MAX.
  - credit_o updates the next cycle; IDLE -> CREDIT.
  - deposit_i = 0 is ignored with no pulse.
  - Overflow: credit unchanged, reject_o pulses the next cycle.
  - Arithmetic is done at CREDIT_W+1 bits to detect overflow.
- Deposit in VEND or CHANGE: refused, reject_o pulses.
- Select in CREDIT:
  - credit >= PRICE[sel_i]: next cycle VEND.
  - Otherwise: insufficient_o pulses next cycle, state unchanged.
  - Select in IDLE: insufficient_o.
- VEND:
  - vend_o = 1 and vend_item_o = latched sel.
  - credit -= price, visible on credit_o the following cycle.
  - Next state: IDLE if the remaining credit is 0, else CHANGE.
- Cancel in CREDIT: -> CHANGE with the full credit. Cancel in IDLE, VEND or CHANGE is ignored.
- CHANGE:
  - change_valid_o = 1.
  - change_coin_o = largest of {20, 10, 5, 1} that is <= credit.
  - Valid/ready handshake: coin value held stable while change_ready_i = 0.
  - On valid & ready: credit -= coin in the same cycle's update.
  - When credit reaches 0: next state IDLE, change_valid_o drops.
- Outputs are all registered or Moore-decoded; there is no combinational input-to-output path.

Optional Feature:
- Macro: VEND_TIMEOUT_EN.
- Defined:
  - A counter of $clog2(TIMEOUT_CYC) bits runs in CREDIT.
  - It clears on any accepted deposit, any select, or on entering CREDIT.
  - On reaching TIMEOUT_CYC-1: timeout_o pulses and the state goes to CHANGE, refunding the full credit.
  - If cancel_i arrives in the same cycle, cancel takes precedence and timeout_o stays 0.
- Not defined: no counter, CREDIT persists indefinitely, timeout_o = 0.

Decomposition:
- Package vend_pkg:
  - state enum {IDLE, CREDIT, VEND, CHANGE}.
  - DENOM_20/10/5/1 constants.
  - COIN_W = 5.
- One sub-module, vend_change_pick: combinational credit -> largest payable denomination.
- FSM, credit register and timeout counter stay in the top-level module.

Test Plan:
1. Deposits 20, 10 -> credit_o 20 then 30. Select 1 -> vend_o pulse with vend_item_o = 1, credit 5. Change: one coin of 5 with ready high, then IDLE, credit 0.
2. Deposits 20, 20, 20 -> third deposit gives a reject_o pulse, credit 40. Select 3 -> insufficient_o pulse, credit stays 40, no vend_o.
3. Credit 37 (20+10+5+1+1), then cancel -> change coins 20, 10, 5, 1, 1 in order. With change_ready_i held low for 3 cycles on the first coin, change_coin_o holds 20.
4. Credit 30 with cancel_i, sel_valid_i (item 2) and deposit_valid_i (deposit_i = 5) asserted in the same cycle -> refund of 30, no vend_o. Deposit not accepted: credit stays 30, no reject_o pulse, payout coins 20, 10 only.
5. rst_i asserted during CHANGE with 15 remaining -> next cycle: credit_o 0, change_valid_o 0, busy_o 0, state IDLE.
6. VEND_TIMEOUT_EN with TIMEOUT_CYC = 8: deposit 10, then 8 idle cycles -> timeout_o pulse, refund coin 10, back to IDLE.
